primos_pares_scanner: RTL

//  Stimulus/check engine for the 4-bit prime/even detector (PRIMOS_PARES).
//  On START, drives D,C,B,A (D = MSB) through codes 0..15, holds each code for

---
 rtl/primos_pares_scanner.sv | 92 +++++++++
 1 files changed

// File: rtl/primos_pares_scanner.sv
// primos_pares_scanner: sweeps codes 0..15 into a prime/even detector and checks its outputs.
// Optional feature: define PPS_HALT_ON_ERR_EN to end the sweep at the first mismatching sample.
module primos_pares_scanner #(
   parameter int HOLD_CYCLES = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       primos,
   input  logic       pares,
   output logic       d,
   output logic       c,
   output logic       b,
   output logic       a,
   output logic [3:0] code,
   output logic       busy,
   output logic       done,
   output logic [4:0] prime_cnt,
   output logic [4:0] even_cnt,
   output logic       err,
   output logic [3:0] err_code
);
   typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;
   localparam logic [15:0] PRIMES = 16'b0010_1000_1010_1100;
   localparam logic [7:0]  LAST   = 8'(HOLD_CYCLES - 1);
   state_t     state;
   logic [7:0] hold;
   logic       miss;
   logic       halt;
   assign {d, c, b, a} = code;
   // golden comparison for the code currently on the detector
   always_comb begin
      miss = (primos != PRIMES[code]) || (pares != ~code[0]);
`ifdef PPS_HALT_ON_ERR_EN
      halt = miss;
`else
      halt = 1'b0;
`endif
   end
   // sweep sequencer: accept START, hold each code, sample at end of hold, pulse DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold      <= '0;
         code      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         prime_cnt <= '0;
         even_cnt  <= '0;
         err       <= 1'b0;
         err_code  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               prime_cnt <= '0;
               even_cnt  <= '0;
               err       <= 1'b0;
               err_code  <= '0;
               code      <= '0;
               hold      <= '0;
               busy      <= 1'b1;
               state     <= DRIVE;
            end
            DRIVE: if (hold == LAST) begin
               prime_cnt <= prime_cnt + 5'(primos);
               even_cnt  <= even_cnt + 5'(pares);
               if (miss && !err) begin
                  err      <= 1'b1;
                  err_code <= code;
               end
               if (code == 4'hf || halt) begin
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  code <= code + 4'd1;
                  hold <= '0;
               end
            end else begin
               hold <= hold + 8'd1;
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               code  <= '0;
               hold  <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
